// File: rtl/bin_div_sub_shift.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// subtract-shift step per clock, start/rdy handshake shared with the multiplier.
module bin_div_sub_shift #(
    parameter int DP_WIDTH = 8,
    parameter int BC_SIZE  = $clog2(DP_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*DP_WIDTH-1:0]   dividend,
    input  logic [DP_WIDTH-1:0]     divisor,
    output logic [DP_WIDTH-1:0]     quotient,
    output logic [DP_WIDTH-1:0]     remainder,
    output logic                    rdy,
    output logic                    div_zero,
    output logic                    ovf
);

    localparam int W = DP_WIDTH;

    typedef enum logic [1:0] {
        S_idle      = 2'd0,
        S_check     = 2'd1,
        S_sub_shift = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    b_q, b_d;
    logic [BC_SIZE-1:0] p_q, p_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;

    // E only ever holds the bit shifted out of A within a step; any step that
    // shifts out a 1 also subtracts and clears it, so it never needs to be stored.
    logic            e_sh;
    logic [W-1:0]    a_sh;
    logic [W:0]      rem_ext;
    logic            sub_ok;

    // Shifted partial remainder and W+1-bit trial compare against the divisor
    always_comb begin
        e_sh    = a_q[W-1];
        a_sh    = {a_q[W-2:0], q_q[W-1]};
        rem_ext = {e_sh, a_sh};
        sub_ok  = (rem_ext >= {1'b0, b_q});
    end

    // Controller next-state and datapath next values
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        b_d        = b_q;
        p_d        = p_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_idle: begin
                if (start) begin
                    a_d        = dividend[2*W-1:W];
                    q_d        = dividend[W-1:0];
                    b_d        = divisor;
                    p_d        = BC_SIZE'(W);
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = S_check;
                end
            end
            S_check: begin
                if (b_q == '0) begin
                    div_zero_d = 1'b1;
                    state_d    = S_idle;
                end else if (a_q >= b_q) begin
                    ovf_d   = 1'b1;
                    state_d = S_idle;
                end else begin
                    state_d = S_sub_shift;
                end
            end
            S_sub_shift: begin
                a_d = sub_ok ? W'(rem_ext - {1'b0, b_q}) : a_sh;
                q_d = {q_q[W-2:0], sub_ok};
                p_d = p_q - BC_SIZE'(1);
                if (p_q == BC_SIZE'(1)) begin
                    state_d = S_idle;
                end
            end
            default: state_d = S_idle;
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_idle;
            a_q        <= '0;
            q_q        <= '0;
            b_q        <= '0;
            p_q        <= BC_SIZE'(W);
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            b_q        <= b_d;
            p_q        <= p_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = a_q;
    assign rdy       = (state_q == S_idle);
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_div_sub_shift.sv
// Bench for bin_div_sub_shift: arithmetic reference model plus literal checks.
module tb_bin_div_sub_shift;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           rdy;
    logic           div_zero;
    logic           ovf;

    int n_cmp = 0;
    int n_err = 0;

    bin_div_sub_shift #(.DP_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .rdy       (rdy),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy countdown and the result expected once idle again
    int           m_busy = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_dz = 1'b0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
        end else if (start === 1'b1) begin
            if (divisor == 0) begin
                m_busy <= 1;
                m_dz   <= 1'b1;
                m_ovf  <= 1'b0;
                m_q    <= dividend[W-1:0];
                m_r    <= dividend[2*W-1:W];
            end else if (dividend[2*W-1:W] >= divisor) begin
                m_busy <= 1;
                m_dz   <= 1'b0;
                m_ovf  <= 1'b1;
                m_q    <= dividend[W-1:0];
                m_r    <= dividend[2*W-1:W];
            end else begin
                m_busy <= W + 1;
                m_dz   <= 1'b0;
                m_ovf  <= 1'b0;
                m_q    <= W'(dividend / {8'd0, divisor});
                m_r    <= W'(dividend % {8'd0, divisor});
            end
        end
    end

    // Compare process: rdy every cycle, results and flags whenever idle
    always @(negedge clk) begin
        check("rdy", 32'(rdy), 32'(m_busy == 0));
        if (m_busy == 0) begin
            check("quotient", 32'(quotient), 32'(m_q));
            check("remainder", 32'(remainder), 32'(m_r));
            check("div_zero", 32'(div_zero), 32'(m_dz));
            check("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    // Launch one operation and count busy cycles; optionally pulse start mid-run
    task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                          input bit pulse_mid, output int busy);
        @(posedge clk); #1;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy  = 0;
        while (!rdy && busy < 50) begin
            busy++;
            if (pulse_mid && busy == 3) begin
                start    = 1'b1;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (busy >= 50) check("timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                                 input logic dz, input logic ov, input int busy, input int lat);
        check({name, "_q"}, 32'(quotient), 32'(q));
        check({name, "_r"}, 32'(remainder), 32'(r));
        check({name, "_dz"}, 32'(div_zero), 32'(dz));
        check({name, "_ovf"}, 32'(ovf), 32'(ov));
        check({name, "_lat"}, 32'(busy), 32'(lat));
    endtask

    initial begin
        int busy;
        logic [W-1:0]   dv;
        logic [2*W-1:0] dd;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_q", 32'(quotient), 32'd0);
        check("reset_r", 32'(remainder), 32'd0);
        rst = 1'b0;

        run_op(16'h0064, 8'h07, 1'b0, busy);
        expect_result("basic", 8'h0E, 8'h02, 1'b0, 1'b0, busy, 9);

        run_op(16'h1234, 8'h56, 1'b1, busy);
        expect_result("normal", 8'h36, 8'h10, 1'b0, 1'b0, busy, 9);

        run_op(16'hFEFF, 8'hFF, 1'b0, busy);
        expect_result("max", 8'hFF, 8'hFE, 1'b0, 1'b0, busy, 9);

        run_op(16'h1234, 8'h00, 1'b0, busy);
        expect_result("divzero", 8'h34, 8'h12, 1'b1, 1'b0, busy, 1);

        run_op(16'h0700, 8'h07, 1'b0, busy);
        expect_result("ovf", 8'h00, 8'h07, 1'b0, 1'b1, busy, 1);

        run_op(16'h0000, 8'h00, 1'b0, busy);
        expect_result("zero_prio", 8'h00, 8'h00, 1'b1, 1'b0, busy, 1);

        run_op(16'h0064, 8'h07, 1'b0, busy);
        expect_result("clear", 8'h0E, 8'h02, 1'b0, 1'b0, busy, 9);

        // Reset four cycles into a division
        @(posedge clk); #1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rdy", 32'(rdy), 32'd1);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(16'h0064, 8'h07, 1'b0, busy);
        expect_result("after_abort", 8'h0E, 8'h02, 1'b0, 1'b0, busy, 9);

        // start held high: back-to-back operations, each result shown for one cycle
        @(posedge clk); #1;
        dividend = 16'h1234;
        divisor  = 8'h56;
        start    = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        start = 1'b0;
        busy  = 0;
        while (!rdy && busy < 50) begin
            busy++;
            @(posedge clk); #1;
        end
        if (busy >= 50) check("timeout_held", 32'(busy), 32'd0);

        // Random legal operands
        for (int i = 0; i < 1000; i++) begin
            dv = 8'($urandom_range(1, 255));
            dd[2*W-1:W] = 8'($urandom_range(0, 32'(dv) - 1));
            dd[W-1:0]   = 8'($urandom);
            run_op(dd, dv, ($urandom_range(0, 7) == 0), busy);
            check("rand_identity", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
            check("rand_rem_lt_div", 32'(remainder < dv), 32'd1);
            check("rand_lat", 32'(busy), 32'd9);
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
